fp_issue_seq: RTL and testbench

- Front-end sequencer for the FP add/sub unit.
- Buffers incoming operation requests in a small FIFO and issues them one at a time to the unit with a one-cycle START pulse, holding the operands stable while it waits.
- Captures RESULT/FLAGS when the unit asserts VALID_OUT and hands them downstream over a valid/ready handshake.
- Accumulates sticky exception flags and guards against a hung unit with a timeout.

---
 rtl/fp_issue_seq.sv | 178 +++++++++++++++++
 tb/tb_fp_issue_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_issue_seq
// Purpose  : Request FIFO + issue sequencer for the FP add/sub unit, with
//            result capture, sticky exception flags and a hung-unit timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fp_issue_seq #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_op_a,
    input  logic [31:0] in_op_b,
    input  logic [2:0]  in_op_code,
    input  logic        in_mode_fp,
    input  logic        in_round_mode,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [2:0]  op_code,
    output logic        mode_fp,
    output logic        round_mode,
    output logic        start,
    input  logic        valid_out,
    input  logic [31:0] result,
    input  logic [4:0]  flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags,
    output logic [4:0]  sticky_flags,
    input  logic        clr_sticky,
    output logic        timeout_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0]    c_idle     = 2'd0;
    localparam logic [1:0]    c_issue    = 2'd1;
    localparam logic [1:0]    c_wait     = 2'd2;
    localparam logic [PW:0]   c_depth    = PW'(0) + (PW+1)'(DEPTH);
    localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

    logic [68:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count;
    logic [1:0]    r_state, w_next_state;
    logic [TW-1:0] r_tmo_cnt;
    logic [68:0]   w_head;
    logic          w_push, w_pop, w_capture, w_timeout;
    logic [4:0]    w_sticky_base;

    logic [31:0] r_op_a, r_op_b, r_out_result;
    logic [2:0]  r_op_code;
    logic        r_mode_fp, r_round_mode, r_out_valid, r_timeout_err;
    logic [4:0]  r_out_flags, r_sticky;

    // Readiness comes from the count register alone so it never depends on pop.
    assign in_ready      = (r_count < c_depth);
    assign w_push        = in_valid & in_ready;
    assign w_head        = r_mem[r_rd_ptr];
    assign w_sticky_base = clr_sticky ? 5'd0 : r_sticky;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {in_op_a, in_op_b, in_op_code, in_mode_fp, in_round_mode};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_pop) w_next_state = c_issue;
            c_issue: w_next_state = valid_out ? c_idle : c_wait;
            c_wait:  if (valid_out || (r_tmo_cnt == c_tmo_last)) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // A pop is only allowed when the output slot is free or draining this cycle.
    always_comb begin
        start     = (r_state == c_issue);
        w_pop     = (r_state == c_idle) && (r_count != '0) && (!r_out_valid || out_ready);
        w_capture = ((r_state == c_issue) || (r_state == c_wait)) && valid_out;
        w_timeout = (r_state == c_wait) && !valid_out && (r_tmo_cnt == c_tmo_last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == c_issue) begin
            r_tmo_cnt <= '0;
        end else if (r_state == c_wait && !valid_out && r_tmo_cnt != c_tmo_last) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_code    <= '0;
            r_mode_fp    <= 1'b0;
            r_round_mode <= 1'b0;
        end else if (w_pop) begin
            {r_op_a, r_op_b, r_op_code, r_mode_fp, r_round_mode} <= w_head;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_flags   <= '0;
            r_sticky      <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_capture) begin
            r_out_valid  <= 1'b1;
            r_out_result <= result;
            r_out_flags  <= flags;
            r_sticky     <= w_sticky_base | flags;
        end else if (w_timeout) begin
            // Substitute a quiet NaN of the issued precision and flag invalid.
            r_out_valid   <= 1'b1;
            r_out_result  <= r_mode_fp ? 32'h7FC0_0000 : 32'h0000_7E00;
            r_out_flags   <= 5'b10000;
            r_sticky      <= w_sticky_base | 5'b10000;
            r_timeout_err <= 1'b1;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (clr_sticky) begin
                r_sticky <= '0;
            end
        end
    end

    assign op_a         = r_op_a;
    assign op_b         = r_op_b;
    assign op_code      = r_op_code;
    assign mode_fp      = r_mode_fp;
    assign round_mode   = r_round_mode;
    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_flags    = r_out_flags;
    assign sticky_flags = r_sticky;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_fp_issue_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_issue_seq
// Purpose  : Directed self-checking bench for fp_issue_seq with a simple
//            behavioural FP unit (fixed or XOR result, programmable latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_issue_seq;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_mode_fp, in_round_mode;
    logic [31:0] in_op_a, in_op_b, op_a, op_b, result, out_result;
    logic [2:0]  in_op_code, op_code;
    logic        mode_fp, round_mode, start, valid_out, out_valid, out_ready;
    logic [4:0]  flags, out_flags, sticky_flags;
    logic        clr_sticky, timeout_err;

    // Unit model controls
    logic        unit_en, valid_force, fixed_sel;
    logic [31:0] fixed_result;
    logic [4:0]  unit_flags;
    int          unit_lat;
    logic        busy;
    int          dcnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_issue_seq #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op_a(in_op_a), .in_op_b(in_op_b), .in_op_code(in_op_code),
        .in_mode_fp(in_mode_fp), .in_round_mode(in_round_mode),
        .op_a(op_a), .op_b(op_b), .op_code(op_code),
        .mode_fp(mode_fp), .round_mode(round_mode), .start(start),
        .valid_out(valid_out), .result(result), .flags(flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .sticky_flags(sticky_flags), .clr_sticky(clr_sticky),
        .timeout_err(timeout_err)
    );

    always @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            dcnt <= 0;
        end else if (start) begin
            busy <= (unit_lat != 0);
            dcnt <= 0;
        end else if (busy) begin
            dcnt <= dcnt + 1;
            if (valid_out) busy <= 1'b0;
        end
    end

    assign valid_out = valid_force |
                       (unit_en & ((unit_lat == 0) ? start : (busy && dcnt == unit_lat - 1)));
    assign result    = fixed_sel ? fixed_result : (op_a ^ op_b);
    assign flags     = unit_flags;

    task automatic do_push(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] code, input logic mfp);
        int n = 0;
        in_op_a = a; in_op_b = b; in_op_code = code; in_mode_fp = mfp; in_round_mode = 1'b0;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL push_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({out_valid, start, timeout_err, sticky_flags, out_flags} !== 13'd0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required 0", {out_valid, start, timeout_err, sticky_flags, out_flags});
        end
        tests++;
        if ({op_a, op_b, op_code, mode_fp, round_mode, out_result} !== 101'd0) begin
            fails++;
            $display("FAIL reset_data: op_a=%h op_b=%h out_result=%h, required 0", op_a, op_b, out_result);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_op;
        unit_en = 1'b1; unit_lat = 0; fixed_sel = 1'b1;
        fixed_result = 32'h4040_0000; unit_flags = 5'd0; out_ready = 1'b0;
        do_push(32'h3F80_0000, 32'h4000_0000, 3'd0, 1'b1);
        tests++;
        if ({start, out_valid} !== 2'b00) begin
            fails++;
            $display("FAIL single_edge1: start,out_valid=%b, required 00", {start, out_valid});
        end
        @(posedge clk); #1;
        tests++;
        if ({start, out_valid} !== 2'b10 || op_a !== 32'h3F80_0000 || op_b !== 32'h4000_0000) begin
            fails++;
            $display("FAIL single_issue: start,out_valid=%b op_a=%h op_b=%h, required 10 3f800000 40000000",
                     {start, out_valid}, op_a, op_b);
        end
        @(posedge clk); #1;
        tests++;
        if ({start, out_valid} !== 2'b01 || out_result !== 32'h4040_0000 || sticky_flags !== 5'd0) begin
            fails++;
            $display("FAIL single_result: start,out_valid=%b result=%h sticky=%b, required 01 40400000 00000",
                     {start, out_valid}, out_result, sticky_flags);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drain: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_res [6];
        logic [31:0] a_tab [6];
        int got = 0;
        int n = 0;
        logic acc;
        a_tab   = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000, 32'h5555_0000, 32'h6666_0000};
        exp_res = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005, 32'h6666_0006};
        unit_en = 1'b1; unit_lat = 0; fixed_sel = 1'b0; unit_flags = 5'd0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_push(a_tab[i], 32'(i + 1), 3'd1, 1'b1);
        end
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_full: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
        end
        in_op_a = a_tab[5]; in_op_b = 32'd6; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold: in_ready=%b, required 0", in_ready);
        end
        out_ready = 1'b1;
        while (got < 6 && n < 200) begin
            if (out_valid) begin
                tests++;
                if (out_result !== exp_res[got]) begin
                    fails++;
                    $display("FAIL bp_order%0d: result=%h, required %h", got, out_result, exp_res[got]);
                end
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            n++;
        end
        if (got < 6) begin
            tests++; fails++;
            $display("FAIL bp_count: delivered %0d, required 6", got);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_delayed_unit;
        logic stable = 1'b1;
        unit_en = 1'b1; unit_lat = 5; fixed_sel = 1'b1;
        fixed_result = 32'h1234_5678; unit_flags = 5'b00001; out_ready = 1'b0;
        do_push(32'h1111_1111, 32'h2222_2222, 3'd1, 1'b1);
        @(posedge clk); #1;
        tests++;
        if (start !== 1'b1) begin
            fails++;
            $display("FAIL dly_start: start=%b, required 1", start);
        end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (start !== 1'b0 || out_valid !== 1'b0 ||
                op_a !== 32'h1111_1111 || op_b !== 32'h2222_2222) stable = 1'b0;
        end
        tests++;
        if (stable !== 1'b1) begin
            fails++;
            $display("FAIL dly_wait_stable: op_a=%h op_b=%h out_valid=%b, required 11111111 22222222 0",
                     op_a, op_b, out_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_flags !== 5'b00001 || sticky_flags !== 5'b00001 ||
            timeout_err !== 1'b0 || out_result !== 32'h1234_5678) begin
            fails++;
            $display("FAIL dly_result: v=%b flags=%b sticky=%b terr=%b res=%h, required 1 00001 00001 0 12345678",
                     out_valid, out_flags, sticky_flags, timeout_err, out_result);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        unit_lat = 0;
    endtask

    task automatic test_timeout;
        logic quiet = 1'b1;
        unit_en = 1'b0; unit_lat = 0; fixed_sel = 1'b1;
        fixed_result = 32'hAABB_CCDD; unit_flags = 5'd0; out_ready = 1'b0;
        do_push(32'h0000_3C00, 32'h0000_4000, 3'd0, 1'b0);
        do_push(32'h5A5A_5A5A, 32'hA5A5_A5A5, 3'd1, 1'b1);
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || timeout_err !== 1'b0) quiet = 1'b0;
        end
        tests++;
        if (quiet !== 1'b1) begin
            fails++;
            $display("FAIL tmo_early: out_valid=%b terr=%b, required 0 0", out_valid, timeout_err);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_result !== 32'h0000_7E00 || out_flags !== 5'b10000 ||
            timeout_err !== 1'b1 || sticky_flags !== 5'b10001) begin
            fails++;
            $display("FAIL tmo_capture: v=%b res=%h flags=%b terr=%b sticky=%b, required 1 00007e00 10000 1 10001",
                     out_valid, out_result, out_flags, timeout_err, sticky_flags);
        end
        unit_en = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (start !== 1'b1 || op_a !== 32'h5A5A_5A5A || mode_fp !== 1'b1) begin
            fails++;
            $display("FAIL tmo_next_issue: start=%b op_a=%h mode_fp=%b, required 1 5a5a5a5a 1",
                     start, op_a, mode_fp);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_result !== 32'hAABB_CCDD || timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL tmo_next_result: v=%b res=%h terr=%b, required 1 aabbccdd 1",
                     out_valid, out_result, timeout_err);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_sticky_clear;
        unit_en = 1'b1; unit_lat = 0; fixed_sel = 1'b1; fixed_result = 32'h0;
        out_ready = 1'b1;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        tests++;
        if (sticky_flags !== 5'd0) begin
            fails++;
            $display("FAIL sticky_clr_idle: sticky=%b, required 00000", sticky_flags);
        end
        unit_flags = 5'b00011;
        do_push(32'h1, 32'h2, 3'd0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (sticky_flags !== 5'b00011) begin
            fails++;
            $display("FAIL sticky_accum: sticky=%b, required 00011", sticky_flags);
        end
        unit_flags = 5'b00100;
        do_push(32'h3, 32'h4, 3'd0, 1'b1);
        @(posedge clk); #1;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        tests++;
        if (sticky_flags !== 5'b00100 || out_flags !== 5'b00100 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL sticky_race: sticky=%b flags=%b v=%b, required 00100 00100 1",
                     sticky_flags, out_flags, out_valid);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        unit_flags = 5'd0;
    endtask

    task automatic test_reset_mid_op;
        logic silent = 1'b1;
        unit_en = 1'b0; unit_lat = 0; out_ready = 1'b0;
        do_push(32'hCAFE_0001, 32'h1, 3'd0, 1'b1);
        do_push(32'hCAFE_0002, 32'h2, 3'd0, 1'b1);
        do_push(32'hCAFE_0003, 32'h3, 3'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests++;
        if ({out_valid, start, timeout_err, sticky_flags, out_flags, op_a, out_result} !== 77'd0 ||
            in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid: v=%b st=%b terr=%b sticky=%b op_a=%h res=%h in_ready=%b, required all 0, in_ready 1",
                     out_valid, start, timeout_err, sticky_flags, op_a, out_result, in_ready);
        end
        unit_flags = 5'b11111; valid_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        valid_force = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid !== 1'b0 || start !== 1'b0 || sticky_flags !== 5'd0) silent = 1'b0;
            @(posedge clk); #1;
        end
        tests++;
        if (silent !== 1'b1) begin
            fails++;
            $display("FAIL rst_late_valid: v=%b st=%b sticky=%b, required 0 0 00000",
                     out_valid, start, sticky_flags);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op_a = '0; in_op_b = '0; in_op_code = '0;
        in_mode_fp = 1'b0; in_round_mode = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        unit_en = 1'b0; valid_force = 1'b0; fixed_sel = 1'b1; fixed_result = '0;
        unit_flags = '0; unit_lat = 0;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_delayed_unit();
        test_timeout();
        test_sticky_clear();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
